// File: rtl/key_debounce_reader.sv
// Push-button front end: per-key 2-FF synchroniser, debounce FSM and counter,
// producing debounced levels, one-cycle press/release pulses and a press toggle.
module key_debounce_reader #(
  parameter int          NKEYS        = 4,
  parameter logic [31:0] DEBOUNCE_CNT = 32'd500000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_toggle,
  output logic             any_press
);

  localparam int            CW       = $clog2(DEBOUNCE_CNT + 32'd1);
  localparam logic [CW-1:0] CNT_MAX  = DEBOUNCE_CNT[CW-1:0];
  localparam logic          PIN_IDLE = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DOWN,
    DISARM
  } state_t;

  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] pressed;
  logic [NKEYS-1:0] press_nxt_all;

  // Synchronisers reset to the idle pin level so leaving reset never looks like an edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= {NKEYS{PIN_IDLE}};
      sync2 <= {NKEYS{PIN_IDLE}};
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level;
    logic          level_nxt;
    logic          toggle;
    logic          toggle_nxt;
    logic          press_q;
    logic          press_nxt;
    logic          release_q;
    logic          release_nxt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        level     <= 1'b0;
        toggle    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level     <= level_nxt;
        toggle    <= toggle_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = level;
      toggle_nxt  = toggle;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      unique case (state)
        IDLE: begin
          if (pressed[i]) begin
            state_nxt = ARM;
            cnt_nxt   = CW'(1);
          end
        end
        ARM: begin
          if (!pressed[i]) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_MAX) begin
            state_nxt  = DOWN;
            press_nxt  = 1'b1;
            level_nxt  = 1'b1;
            toggle_nxt = ~toggle;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DOWN: begin
          if (!pressed[i]) begin
            state_nxt = DISARM;
            cnt_nxt   = CW'(1);
          end
        end
        DISARM: begin
          if (pressed[i]) begin
            state_nxt = DOWN;
          end else if (cnt == CNT_MAX) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
            level_nxt   = 1'b0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign key_level[i]     = level;
    assign key_toggle[i]    = toggle;
    assign key_press[i]     = press_q;
    assign key_release[i]   = release_q;
    assign press_nxt_all[i] = press_nxt;
  end

  // Registered from the next-state pulses so it lines up with key_press, not a cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_nxt_all;
    end
  end

endmodule

// File: tb/tb_key_debounce_reader.sv
// Scoreboard bench for key_debounce_reader: stimulus pushes expected events,
// a negedge monitor pops and compares them when the DUT pulses.
module tb_key_debounce_reader;

  localparam int NK  = 4;
  localparam int DEB = 8;
  localparam int LAT = DEB + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_toggle;
  logic          any_press;

  key_debounce_reader #(
    .NKEYS       (NK),
    .DEBOUNCE_CNT(32'd8),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] level;
    logic [NK-1:0] toggle;
  } evt_t;

  evt_t          sb[$];
  int            cyc = 0;
  logic          rst_seen = 1'b0;
  int            n_checks = 0;
  int            n_err = 0;
  logic [NK-1:0] mdl_level = '0;
  logic [NK-1:0] mdl_toggle = '0;
  logic [NK-1:0] cur_level = '0;
  logic [NK-1:0] cur_toggle = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  always @(negedge clk) begin
    if (!rst_seen) begin
      check("reset_outputs", 32'({key_level, key_press, key_release, key_toggle, any_press}), 32'd0);
      cur_level  = '0;
      cur_toggle = '0;
    end else if (key_press != '0 || key_release != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 32'({key_press, key_release}), 32'd0);
      end else begin
        evt_t e;
        e = sb.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("press", 32'(key_press), 32'(e.press));
        check("release", 32'(key_release), 32'(e.rel));
        check("any_press", 32'(any_press), 32'(|e.press));
        check("level", 32'(key_level), 32'(e.level));
        check("toggle", 32'(key_toggle), 32'(e.toggle));
        cur_level  = e.level;
        cur_toggle = e.toggle;
      end
    end else begin
      check("steady", 32'({any_press, key_level, key_toggle}), 32'({1'b0, cur_level, cur_toggle}));
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        check("missed_event_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input logic [NK-1:0] p, input logic [NK-1:0] r);
    mdl_level  = (mdl_level | p) & ~r;
    mdl_toggle = mdl_toggle ^ p;
    sb.push_back('{cyc + LAT, p, r, mdl_level, mdl_toggle});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 4 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = '1;
    wait_cyc(3);
    rst_n = 1'b1;

    // Clean press on key 0.
    wait_cyc(10);
    key_in[0] = 1'b0;
    expect_evt(4'b0001, 4'b0000);
    wait_drain();

    // Bouncy press on key 1: a 7-sample run, one high sample, then held low.
    wait_cyc(30);
    key_in[1] = 1'b0;
    wait_cyc(37);
    key_in[1] = 1'b1;
    wait_cyc(38);
    key_in[1] = 1'b0;
    expect_evt(4'b0010, 4'b0000);
    wait_drain();

    // Release key 0, then key 1.
    wait_cyc(50);
    key_in[0] = 1'b1;
    expect_evt(4'b0000, 4'b0001);
    wait_drain();
    wait_cyc(65);
    key_in[1] = 1'b1;
    expect_evt(4'b0000, 4'b0010);
    wait_drain();

    // Two full press/release cycles on key 2.
    for (int k = 0; k < 2; k++) begin
      wait_cyc(80 + k * 30);
      key_in[2] = 1'b0;
      expect_evt(4'b0100, 4'b0000);
      wait_cyc(95 + k * 30);
      key_in[2] = 1'b1;
      expect_evt(4'b0000, 4'b0100);
    end
    wait_drain();

    // All four keys together.
    wait_cyc(160);
    key_in = 4'b0000;
    expect_evt(4'b1111, 4'b0000);
    wait_cyc(180);
    key_in = 4'b1111;
    expect_evt(4'b0000, 4'b1111);
    wait_drain();

    // Reset while key 0 is part way through ARM; it is re-detected afterwards.
    wait_cyc(210);
    key_in[0] = 1'b0;
    wait_cyc(217);
    rst_n      = 1'b0;
    mdl_level  = '0;
    mdl_toggle = '0;
    wait_cyc(220);
    rst_n = 1'b1;
    expect_evt(4'b0001, 4'b0000);
    wait_drain();
    wait_cyc(240);
    key_in[0] = 1'b1;
    expect_evt(4'b0000, 4'b0001);
    wait_drain();

    wait_cyc(cyc + 5);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cyc %0d expected below 400", cyc);
    $fatal(1);
  end

endmodule
